// File: rtl/trdb_pkg.sv
// trdb_pkg: shared geometry, state encoding and byte types for the trace
// stream packer (trdb_stream_packer and its optional stats block).
package trdb_pkg;

  // Default packet and output-word geometry, in bytes.
  localparam int PKT_BYTES  = 16;
  localparam int WORD_BYTES = 4;

  // One word's worth of residue minus a byte, plus a full packet: the most
  // the packer ever has to hold at once.
  localparam int BUF_BYTES  = WORD_BYTES - 1 + PKT_BYTES;

  // Width of the optional packet/word statistics counters.
  localparam int STAT_W     = 32;

  // Packer control states.
  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    FLUSH
  } pack_state_e;

  // Byte element and the byte buffer at default geometry; index 0 is the
  // oldest byte, i.e. the next one to leave in an output word.
  typedef logic [7:0] byte_t;
  typedef byte_t [BUF_BYTES-1:0] byte_buf_t;

endpackage

// File: rtl/trdb_packer_stats.sv
// trdb_packer_stats: accepted-packet and emitted-word counters for the trace
// stream packer. Both wrap naturally; a clear request beats an increment.
module trdb_packer_stats
  import trdb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              pkt_inc_i,
  input  logic              word_inc_i,
  output logic [STAT_W-1:0] pkt_cnt_o,
  output logic [STAT_W-1:0] word_cnt_o
);

  // Counter registers: clear has priority over counting in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_cnt_o  <= '0;
      word_cnt_o <= '0;
    end else if (clear_i) begin
      pkt_cnt_o  <= '0;
      word_cnt_o <= '0;
    end else begin
      if (pkt_inc_i)  pkt_cnt_o  <= pkt_cnt_o + STAT_W'(1);
      if (word_inc_i) word_cnt_o <= word_cnt_o + STAT_W'(1);
    end
  end

endmodule

// File: rtl/trdb_stream_packer.sv
// trdb_stream_packer: packs variable-length trace packets (1..PKT_W/8 bytes)
// back-to-back into WORD_W-bit little-endian words. Bytes that do not fill a
// word stay in the buffer for the next packet or leave as a partial word on
// flush (byte enables mark the valid bytes).
// Optional build macro TRDB_PACKER_STATS_EN adds packet/word counters with
// ports stats_clear_i, pkt_cnt_o and word_cnt_o.
module trdb_stream_packer
  import trdb_pkg::*;
#(
  parameter int PKT_W  = PKT_BYTES * 8,
  parameter int WORD_W = WORD_BYTES * 8,
  parameter int LEN_W  = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                pkt_valid_i,
  output logic                pkt_ready_o,
  input  logic [PKT_W-1:0]    pkt_data_i,
  input  logic [LEN_W-1:0]    pkt_len_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WORD_W-1:0]   out_data_o,
  output logic [WORD_W/8-1:0] out_be_o,
`ifdef TRDB_PACKER_STATS_EN
  input  logic                stats_clear_i,
  output logic [STAT_W-1:0]   pkt_cnt_o,
  output logic [STAT_W-1:0]   word_cnt_o,
`endif
  output logic                idle_o
);

  localparam int PB    = PKT_W / 8;
  localparam int WB    = WORD_W / 8;
  localparam int BUF_B = WB - 1 + PB;
  localparam int BUF_W = BUF_B * 8;
  localparam int CNT_W = $clog2(BUF_B + 1);

  pack_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;          // valid bytes held in buf_q
  logic                flush_pend_q, flush_pend_d;
  logic                run_q;                 // first clock after reset seen
  byte_t [BUF_B-1:0]   buf_q, buf_d;

  logic [CNT_W-1:0]    len_c;                 // clamped packet length
  logic [CNT_W-1:0]    total;                 // bytes held after an append
  logic [CNT_W-1:0]    rem;                   // bytes held after one word leaves
  logic [BUF_W-1:0]    ins_data;              // packet aligned to the fill point
  logic [BUF_B-1:0]    ins_mask;              // buffer bytes the packet covers

  // Oversized lengths are clamped to a full packet.
  assign len_c    = (pkt_len_i > LEN_W'(PB)) ? CNT_W'(PB) : CNT_W'(pkt_len_i);
  assign total    = cnt_q + len_c;
  assign rem      = cnt_q - CNT_W'(WB);
  assign ins_data = BUF_W'(pkt_data_i) << {cnt_q, 3'b000};
  assign ins_mask = ((BUF_B'(1) << len_c) - BUF_B'(1)) << cnt_q;

  assign idle_o = (state_q == IDLE) && (cnt_q == '0) && !flush_pend_q;

  // Control registers: state, fill level, deferred flush, out-of-reset flag.
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge value of its inputs; blocking (=) here
  // would make results depend on block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      run_q        <= 1'b1;
    end
  end

  // Byte buffer storage.
  // NOTE: the buffer is deliberately not reset; cnt_q = 0 marks every byte
  // dead, and output bytes are only driven from positions below cnt_q or
  // while a full word is present, so stale contents never escape.
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

  // Next-state, buffer update and output decode.
  always_comb begin
    // NOTE: every signal written below gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    buf_d        = buf_q;
    pkt_ready_o  = 1'b0;
    out_valid_o  = 1'b0;
    out_data_o   = '0;
    out_be_o     = '0;

    unique case (state_q)
      IDLE: begin
        pkt_ready_o = run_q;
        if (run_q && pkt_valid_i) begin
          // Append the packet behind the residue; a flush in the same cycle
          // applies to whatever residue the append leaves.
          for (int i = 0; i < BUF_B; i++) begin
            if (ins_mask[i]) buf_d[i] = ins_data[8*i +: 8];
          end
          cnt_d = total;
          if (total >= CNT_W'(WB)) begin
            state_d      = EMIT;
            flush_pend_d = flush_i;
          end else if (flush_i && (total != '0)) begin
            state_d = FLUSH;
          end
        end else if (flush_i && (cnt_q != '0)) begin
          state_d = FLUSH;
        end
      end

      EMIT: begin
        out_valid_o = 1'b1;
        out_data_o  = buf_q[WB-1:0];
        out_be_o    = '1;
        if (flush_i) flush_pend_d = 1'b1;
        if (out_ready_i) begin
          buf_d = buf_q >> WORD_W;
          cnt_d = rem;
          if (rem < CNT_W'(WB)) begin
            flush_pend_d = 1'b0;
            state_d      = ((flush_pend_q || flush_i) && (rem != '0)) ? FLUSH : IDLE;
          end
        end
      end

      FLUSH: begin
        out_valid_o = 1'b1;
        for (int i = 0; i < WB; i++) begin
          out_data_o[8*i +: 8] = (CNT_W'(i) < cnt_q) ? buf_q[i] : 8'h00;
        end
        out_be_o = (WB'(1) << cnt_q) - WB'(1);
        if (out_ready_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef TRDB_PACKER_STATS_EN
  // Optional statistics: non-empty packets accepted, words handed off.
  trdb_packer_stats u_stats (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (stats_clear_i),
    .pkt_inc_i  (pkt_ready_o && pkt_valid_i && (len_c != '0)),
    .word_inc_i (out_valid_o && out_ready_i),
    .pkt_cnt_o  (pkt_cnt_o),
    .word_cnt_o (word_cnt_o)
  );
`endif

endmodule

// File: tb/tb_trdb_stream_packer.sv
// tb_trdb_stream_packer: table-driven vectors, hand-written corner sequences
// and a randomized phase, all checked against a byte-queue reference model.
module tb_trdb_stream_packer;

  localparam int PKT_W  = 128;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 5;
  localparam logic [127:0] DATA16 = 128'h0F0E0D0C0B0A09080706050403020100;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               pkt_valid_i = 1'b0;
  logic               pkt_ready_o;
  logic [PKT_W-1:0]   pkt_data_i = '0;
  logic [LEN_W-1:0]   pkt_len_i = '0;
  logic               flush_i = 1'b0;
  logic               out_valid_o;
  logic               out_ready_i = 1'b1;
  logic [WORD_W-1:0]  out_data_o;
  logic [3:0]         out_be_o;
  logic               idle_o;
`ifdef TRDB_PACKER_STATS_EN
  logic               stats_clear_i = 1'b0;
  logic [31:0]        pkt_cnt_o;
  logic [31:0]        word_cnt_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  trdb_stream_packer #(.PKT_W(PKT_W), .WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .pkt_valid_i (pkt_valid_i),
    .pkt_ready_o (pkt_ready_o),
    .pkt_data_i  (pkt_data_i),
    .pkt_len_i   (pkt_len_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_be_o    (out_be_o),
`ifdef TRDB_PACKER_STATS_EN
    .stats_clear_i (stats_clear_i),
    .pkt_cnt_o     (pkt_cnt_o),
    .word_cnt_o    (word_cnt_o),
`endif
    .idle_o      (idle_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: byte stream -> words ----------------
  logic [7:0]  m_res[$];      // accepted bytes not yet in a word
  logic [35:0] m_exp[$];      // expected {be, data} words, in order
  int unsigned m_pkts, m_words;
  logic        prev_stall;
  logic [35:0] prev_word;

  always @(negedge clk_i) begin : monitor
    int          n;
    logic [31:0] w;
    logic [3:0]  be;
    logic [35:0] ew;
    if (!rst_ni) begin
      m_res.delete();
      m_exp.delete();
      m_pkts     = 0;
      m_words    = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", out_valid_o, 1'b1);
        check("stall_word_stable", {out_be_o, out_data_o}, prev_word);
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_word  = {out_be_o, out_data_o};

      if (out_valid_o && out_ready_i) begin
        m_words++;
        if (m_exp.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL mon_extra_word: got 0x%0h, expected no word", {out_be_o, out_data_o});
        end else begin
          ew = m_exp.pop_front();
          check("mon_word", {out_be_o, out_data_o}, ew);
        end
      end

      if (pkt_valid_i && pkt_ready_o) begin
        n = (int'(pkt_len_i) > 16) ? 16 : int'(pkt_len_i);
        if (n > 0) m_pkts++;
        for (int i = 0; i < n; i++) m_res.push_back(pkt_data_i[8*i +: 8]);
        while (m_res.size() >= 4) begin
          for (int k = 0; k < 4; k++) w[8*k +: 8] = m_res.pop_front();
          m_exp.push_back({4'hF, w});
        end
      end

      if (flush_i && (m_res.size() > 0)) begin
        w  = '0;
        be = '0;
        for (int k = 0; k < 4; k++) begin
          if (m_res.size() > 0) begin
            w[8*k +: 8] = m_res.pop_front();
            be[k]       = 1'b1;
          end
        end
        m_exp.push_back({be, w});
      end
`ifdef TRDB_PACKER_STATS_EN
      if (stats_clear_i) begin
        m_pkts  = 0;
        m_words = 0;
      end
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [35:0] col_q[$];

  // Present one packet (starts and ends at posedge+1); returns just after
  // the accepting edge.
  task automatic send(input logic [4:0] len, input logic [127:0] data, input logic fl);
    int k = 0;
    pkt_valid_i = 1'b1;
    pkt_len_i   = len;
    pkt_data_i  = data;
    flush_i     = fl;
    @(negedge clk_i);
    while (!pkt_ready_o && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    if (!pkt_ready_o) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: pkt_ready_o=0 after %0d cycles, expected 1", k);
    end
    @(posedge clk_i);
    #1;
    pkt_valid_i = 1'b0;
    pkt_len_i   = '0;
    flush_i     = 1'b0;
  endtask

  // Record output handshakes and cycles with pkt_ready_o low.
  task automatic collect(input int cycles, output int busy);
    busy = 0;
    col_q.delete();
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk_i);
      if (!pkt_ready_o) busy++;
      if (out_valid_o && out_ready_i) col_q.push_back({out_be_o, out_data_o});
    end
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic [4:0]   len;
    logic [127:0] data;
    logic         flush;
    int           exp_n;
    logic [35:0]  exp_first;
    logic [35:0]  exp_last;
    int           exp_busy;
    logic         exp_idle;
  } vec_t;

  vec_t vecs[9];

  initial begin : main
    int busy;
    int k;
    logic [35:0] exp_b[5];

    vecs[0] = '{5'd4,  128'hDDCCBBAA, 1'b0, 1, 36'hF_DDCCBBAA, 36'hF_DDCCBBAA, 1, 1'b1};
    vecs[1] = '{5'd3,  128'h332211,   1'b1, 1, 36'h7_00332211, 36'h7_00332211, 1, 1'b1};
    vecs[2] = '{5'd20, DATA16,        1'b0, 4, 36'hF_03020100, 36'hF_0F0E0D0C, 4, 1'b1};
    vecs[3] = '{5'd3,  128'h332211,   1'b0, 0, 36'h0,          36'h0,          0, 1'b0};
    vecs[4] = '{5'd2,  128'h5544,     1'b0, 1, 36'hF_44332211, 36'hF_44332211, 1, 1'b0};
    vecs[5] = '{5'd0,  128'hFFFF,     1'b1, 1, 36'h1_00000055, 36'h1_00000055, 1, 1'b1};
    vecs[6] = '{5'd0,  128'h1234,     1'b1, 0, 36'h0,          36'h0,          0, 1'b1};
    vecs[7] = '{5'd1,  128'hAB,       1'b0, 0, 36'h0,          36'h0,          0, 1'b0};
    vecs[8] = '{5'd3,  128'hCCDDEE,   1'b0, 1, 36'hF_CCDDEEAB, 36'hF_CCDDEEAB, 1, 1'b1};

    // Reset values.
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_pkt_ready", pkt_ready_o, 1'b0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_data", out_data_o, 32'h0);
    check("rst_out_be", out_be_o, 4'h0);
    check("rst_idle", idle_o, 1'b1);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_pkt_ready", pkt_ready_o, 1'b1);

    // Table-driven single-packet vectors (out_ready_i held high).
    foreach (vecs[i]) begin
      send(vecs[i].len, vecs[i].data, vecs[i].flush);
      check($sformatf("vec%0d_latency", i), out_valid_o, vecs[i].exp_n > 0);
      collect(10, busy);
      check($sformatf("vec%0d_nwords", i), col_q.size(), vecs[i].exp_n);
      if (vecs[i].exp_n > 0) begin
        check($sformatf("vec%0d_first", i), col_q[0], vecs[i].exp_first);
        check($sformatf("vec%0d_last", i), col_q[col_q.size()-1], vecs[i].exp_last);
      end
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_idle", i), idle_o, vecs[i].exp_idle);
    end

    // 16-byte packet with the first word stalled for 3 cycles.
    out_ready_i = 1'b0;
    send(5'd16, DATA16, 1'b0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk_i);
      check("stall_first_word", {out_be_o, out_data_o}, 36'hF_03020100);
      check("stall_pkt_ready", pkt_ready_o, 1'b0);
    end
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b1;
    collect(8, busy);
    check("stall_nwords", col_q.size(), 4);
    if (col_q.size() == 4) begin
      check("stall_w0", col_q[0], 36'hF_03020100);
      check("stall_w1", col_q[1], 36'hF_07060504);
      check("stall_w2", col_q[2], 36'hF_0B0A0908);
      check("stall_w3", col_q[3], 36'hF_0F0E0D0C);
    end
    check("stall_busy", busy, 4);
    check("stall_ready_after", pkt_ready_o, 1'b1);

    // Residue of 2, then a 16-byte packet with flush in the same cycle.
    send(5'd2, 128'hBBAA, 1'b0);
    check("r2_no_output", out_valid_o, 1'b0);
    send(5'd16, DATA16, 1'b1);
    collect(10, busy);
    exp_b = '{36'hF_0100BBAA, 36'hF_05040302, 36'hF_09080706, 36'hF_0D0C0B0A, 36'h3_00000F0E};
    check("r2f_nwords", col_q.size(), 5);
    if (col_q.size() == 5) begin
      for (int w = 0; w < 5; w++) check($sformatf("r2f_w%0d", w), col_q[w], exp_b[w]);
    end
    check("r2f_busy", busy, 5);
    check("r2f_idle", idle_o, 1'b1);

    // Reset in the middle of a 16-byte packet.
    send(5'd16, DATA16, 1'b0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check("midrst_out_valid", out_valid_o, 1'b0);
    check("midrst_out_be", out_be_o, 4'h0);
    check("midrst_pkt_ready", pkt_ready_o, 1'b0);
    check("midrst_idle", idle_o, 1'b1);
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst_ready_back", pkt_ready_o, 1'b1);
    send(5'd4, 128'h44332211, 1'b0);
    collect(6, busy);
    check("midrst_nwords", col_q.size(), 1);
    if (col_q.size() > 0) check("midrst_word", col_q[0], 36'hF_44332211);
    check("midrst_idle_after", idle_o, 1'b1);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      pkt_valid_i = ($urandom_range(0, 1) == 1);
      pkt_len_i   = 5'($urandom_range(0, 20));
      pkt_data_i  = {$urandom, $urandom, $urandom, $urandom};
      flush_i     = ($urandom_range(0, 9) == 0);
      out_ready_i = ($urandom_range(0, 3) != 0);
`ifdef TRDB_PACKER_STATS_EN
      stats_clear_i = ($urandom_range(0, 63) == 0);
`endif
      @(posedge clk_i);
      #1;
    end
    pkt_valid_i = 1'b0;
    out_ready_i = 1'b1;
`ifdef TRDB_PACKER_STATS_EN
    stats_clear_i = 1'b0;
`endif
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    k = 0;
    @(negedge clk_i);
    while (!idle_o && k < 60) begin
      @(negedge clk_i);
      k++;
    end
    check("rand_drain_idle", idle_o, 1'b1);
    check("rand_model_words_left", m_exp.size(), 0);
    check("rand_model_bytes_left", m_res.size(), 0);

`ifdef TRDB_PACKER_STATS_EN
    @(negedge clk_i);
    check("stats_pkt_cnt", pkt_cnt_o, m_pkts);
    check("stats_word_cnt", word_cnt_o, m_words);
    @(posedge clk_i);
    #1;
    stats_clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    stats_clear_i = 1'b0;
    check("stats_clear_pkt", pkt_cnt_o, 32'd0);
    check("stats_clear_word", word_cnt_o, 32'd0);
    send(5'd0, 128'h0, 1'b1);
    collect(3, busy);
    check("stats_len0_pkt", pkt_cnt_o, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
